// File: rtl/scan_sel_if.sv
// Control and select bundle between a scan controller (master) and scan_sel_gen (slave).
// The master drives enable, divider, mask and mode; the slave returns select, valid and wrap.
interface scan_sel_if #(
  parameter int DIV_W = 16
);
  logic             en;
  logic [DIV_W-1:0] div;
  logic [7:0]       mask;
  logic [1:0]       mode;
  logic [2:0]       sel;
  logic             valid;
  logic             wrap;

  modport master (output en, div, mask, mode, input sel, valid, wrap);
  modport slave  (input en, div, mask, mode, output sel, valid, wrap);
endinterface

// File: rtl/scan_sel_gen.sv
// Scan select sequencer: prescaled stepping over 8 masked positions in up, down, ping-pong or hold mode.
//   state  | meaning
//   DIR_UP | ping-pong currently sweeping toward position 7
//   DIR_DN | ping-pong currently sweeping toward position 0
module scan_sel_gen #(
  parameter int DIV_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  scan_sel_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DN   = 2'b01,
    MODE_PP   = 2'b10,
    MODE_HOLD = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_t;

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic [2:0]       r_sel;
  logic [2:0]       w_sel_nxt;
  dir_t             r_dir;
  dir_t             w_dir_nxt;
  logic             r_wrap;
  logic             w_wrap_nxt;
  logic             w_tick;
  mode_t            w_mode;

  // Circular (cu/cd) and non-wrapping (lu/ld) nearest-active searches from r_sel.
  logic [2:0] w_cu_idx, w_cd_idx, w_lu_idx, w_ld_idx;
  logic       w_cu_hit, w_cd_hit, w_lu_hit, w_ld_hit;
  logic       w_cu_cross, w_cd_cross;
  logic [3:0] w_up_sum, w_dn_sum;

  assign w_mode = mode_t'(bus.mode);
  assign w_tick = bus.en && (r_cnt >= bus.div);

  // Descending k so the nearest hit (smallest k) is the one that sticks.
  always_comb begin
    w_cu_idx   = r_sel;
    w_cd_idx   = r_sel;
    w_lu_idx   = r_sel;
    w_ld_idx   = r_sel;
    w_cu_hit   = 1'b0;
    w_cd_hit   = 1'b0;
    w_lu_hit   = 1'b0;
    w_ld_hit   = 1'b0;
    w_cu_cross = 1'b0;
    w_cd_cross = 1'b0;
    w_up_sum   = 4'd0;
    w_dn_sum   = 4'd0;
    for (int k = 7; k >= 1; k--) begin
      w_up_sum = {1'b0, r_sel} + 4'(k);
      w_dn_sum = {1'b0, r_sel} - 4'(k);
      if (bus.mask[w_up_sum[2:0]]) begin
        w_cu_idx   = w_up_sum[2:0];
        w_cu_hit   = 1'b1;
        w_cu_cross = w_up_sum[3];
        if (!w_up_sum[3]) begin
          w_lu_idx = w_up_sum[2:0];
          w_lu_hit = 1'b1;
        end
      end
      if (bus.mask[w_dn_sum[2:0]]) begin
        w_cd_idx   = w_dn_sum[2:0];
        w_cd_hit   = 1'b1;
        w_cd_cross = w_dn_sum[3];
        if (!w_dn_sum[3]) begin
          w_ld_idx = w_dn_sum[2:0];
          w_ld_hit = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_sel_nxt  = r_sel;
    w_dir_nxt  = r_dir;
    w_wrap_nxt = 1'b0;
    if (!bus.en) begin
      w_cnt_nxt = '0;
    end else if (!w_tick) begin
      w_cnt_nxt = r_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
    end else begin
      w_cnt_nxt = '0;
      if (bus.mask != 8'h00) begin
        case (w_mode)
          MODE_UP: begin
            if (w_cu_hit) begin
              w_sel_nxt  = w_cu_idx;
              w_wrap_nxt = w_cu_cross;
            end else begin
              w_wrap_nxt = 1'b1;
            end
          end
          MODE_DN: begin
            if (w_cd_hit) begin
              w_sel_nxt  = w_cd_idx;
              w_wrap_nxt = w_cd_cross;
            end else begin
              w_wrap_nxt = 1'b1;
            end
          end
          MODE_PP: begin
            if (r_dir == DIR_UP) begin
              if (w_lu_hit) begin
                w_sel_nxt = w_lu_idx;
              end else begin
                w_dir_nxt  = DIR_DN;
                w_wrap_nxt = 1'b1;
                if (w_ld_hit) w_sel_nxt = w_ld_idx;
              end
            end else begin
              if (w_ld_hit) begin
                w_sel_nxt = w_ld_idx;
              end else begin
                w_dir_nxt  = DIR_UP;
                w_wrap_nxt = 1'b1;
                if (w_lu_hit) w_sel_nxt = w_lu_idx;
              end
            end
          end
          default: begin
            w_sel_nxt = r_sel;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_sel  <= 3'd0;
      r_dir  <= DIR_UP;
      r_wrap <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_sel  <= w_sel_nxt;
      r_dir  <= w_dir_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  assign bus.sel   = r_sel;
  assign bus.valid = bus.mask[r_sel];
  assign bus.wrap  = r_wrap;

endmodule

// File: tb/tb_scan_sel_gen.sv
// Directed bench for scan_sel_gen: inputs driven and outputs sampled on the falling clock edge.
module tb_scan_sel_gen;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  scan_sel_if #(.DIV_W(16)) bus ();

  scan_sel_gen #(.DIV_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cyc_chk(input string tag, input logic [2:0] es, input logic ew, input logic ev);
    @(negedge clk);
    chk({tag, "_sel"},   {5'b0, bus.sel},   {5'b0, es});
    chk({tag, "_wrap"},  {7'b0, bus.wrap},  {7'b0, ew});
    chk({tag, "_valid"}, {7'b0, bus.valid}, {7'b0, ev});
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;

    // Full mask, up, tick every cycle
    rst_n     = 1'b0;
    bus.en    = 1'b1;
    bus.div   = 16'd0;
    bus.mask  = 8'hFF;
    bus.mode  = 2'b00;
    repeat (2) @(negedge clk);
    chk("rst_sel",   {5'b0, bus.sel},   8'd0);
    chk("rst_wrap",  {7'b0, bus.wrap},  8'd0);
    chk("rst_valid", {7'b0, bus.valid}, 8'd1);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) cyc_chk("up_ff", 3'(i % 8), (i == 8), 1'b1);

    // div=3, then shrink div to 1 with cnt=2
    bus.div = 16'd3;
    cyc_chk("div3_c1", 3'd0, 1'b0, 1'b1);
    cyc_chk("div3_c2", 3'd0, 1'b0, 1'b1);
    cyc_chk("div3_c3", 3'd0, 1'b0, 1'b1);
    cyc_chk("div3_c4", 3'd1, 1'b0, 1'b1);
    cyc_chk("div3_c5", 3'd1, 1'b0, 1'b1);
    cyc_chk("div3_c6", 3'd1, 1'b0, 1'b1);
    bus.div = 16'd1;
    cyc_chk("div1_force", 3'd2, 1'b0, 1'b1);
    cyc_chk("div1_c2",    3'd2, 1'b0, 1'b1);
    cyc_chk("div1_c3",    3'd3, 1'b0, 1'b1);
    cyc_chk("div1_c4",    3'd3, 1'b0, 1'b1);
    cyc_chk("div1_c5",    3'd4, 1'b0, 1'b1);

    // Down mode over mask A5 from 0
    rst_n    = 1'b0;
    bus.div  = 16'd0;
    bus.mode = 2'b01;
    bus.mask = 8'hA5;
    @(negedge clk);
    chk("dn_rst_sel", {5'b0, bus.sel}, 8'd0);
    rst_n = 1'b1;
    cyc_chk("dn_7a", 3'd7, 1'b1, 1'b1);
    cyc_chk("dn_5",  3'd5, 1'b0, 1'b1);
    cyc_chk("dn_2",  3'd2, 1'b0, 1'b1);
    cyc_chk("dn_0",  3'd0, 1'b0, 1'b1);
    cyc_chk("dn_7b", 3'd7, 1'b1, 1'b1);

    // Ping-pong over positions 1,3,4
    rst_n    = 1'b0;
    bus.mode = 2'b00;
    bus.mask = 8'h1A;
    @(negedge clk);
    chk("pp_rst_sel",   {5'b0, bus.sel},   8'd0);
    chk("pp_rst_valid", {7'b0, bus.valid}, 8'd0);
    rst_n    = 1'b1;
    bus.mode = 2'b10;
    cyc_chk("pp_1a", 3'd1, 1'b0, 1'b1);
    cyc_chk("pp_3a", 3'd3, 1'b0, 1'b1);
    cyc_chk("pp_4a", 3'd4, 1'b0, 1'b1);
    cyc_chk("pp_3b", 3'd3, 1'b1, 1'b1);
    cyc_chk("pp_1b", 3'd1, 1'b0, 1'b1);
    cyc_chk("pp_3c", 3'd3, 1'b1, 1'b1);
    cyc_chk("pp_4b", 3'd4, 1'b0, 1'b1);

    // Hold mode
    bus.mode = 2'b11;
    for (int i = 0; i < 3; i++) cyc_chk("hold", 3'd4, 1'b0, 1'b1);

    // Empty mask, then single active position equal to sel
    bus.mode = 2'b00;
    bus.mask = 8'h00;
    for (int i = 0; i < 3; i++) cyc_chk("mask0", 3'd4, 1'b0, 1'b0);
    bus.mask = 8'h10;
    for (int i = 0; i < 3; i++) cyc_chk("single", 3'd4, 1'b1, 1'b1);

    // Enable low freezes everything; prescaler restarts from zero
    rst_n    = 1'b0;
    bus.en   = 1'b0;
    bus.mask = 8'hFF;
    bus.div  = 16'd2;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) cyc_chk("en0", 3'd0, 1'b0, 1'b1);
    bus.en = 1'b1;
    cyc_chk("en1_c1", 3'd0, 1'b0, 1'b1);
    cyc_chk("en1_c2", 3'd0, 1'b0, 1'b1);
    cyc_chk("en1_c3", 3'd1, 1'b0, 1'b1);
    bus.div = 16'd0;
    cyc_chk("run_2", 3'd2, 1'b0, 1'b1);
    cyc_chk("run_3", 3'd3, 1'b0, 1'b1);
    cyc_chk("run_4", 3'd4, 1'b0, 1'b1);
    cyc_chk("run_5", 3'd5, 1'b0, 1'b1);
    bus.div = 16'd3;
    @(negedge clk);
    chk("mid_sel", {5'b0, bus.sel}, 8'd5);

    // Asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_sel",  {5'b0, bus.sel},  8'd0);
    chk("async_wrap", {7'b0, bus.wrap}, 8'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/scan_sel_gen.md
Name: scan_sel_gen

Overview:
- Upstream sequencer that generates the 3-bit select driving the 3-to-8 one-hot decoder (the decoder's a input) for LED/digit scanning.
- Steps through 8 positions at a programmable rate and skips positions disabled by a mask.
- Supports up, down, ping-pong and hold modes.
- Flags each completed sweep and indicates whether the current select is an active position.

Parameters:
- DIV_W, 16, width of the prescaler divide value and its internal counter.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, scan enable.
- div, input, DIV_W, step period minus 1; a step occurs every div+1 enabled cycles.
- mask, input, 8, bit i = 1 means position i is active.
- mode, input, 2, 00 up, 01 down, 10 ping-pong, 11 hold.
- sel, output, 3, current position; feeds the decoder select.
- valid, output, 1, combinational mask[sel]; when low, downstream blanks the decoder output.
- wrap, output, 1, single-cycle pulse when a sweep completes.

Behaviour:
- Reset (async, rst_n=0):
  - sel=0, wrap=0, prescaler cnt=0, ping-pong direction dir=up.
  - valid follows mask[0].
- Prescaler:
  - If en=0: cnt forced to 0, sel and dir held, wrap=0.
  - If en=1 and cnt>=div: tick, and cnt<=0. Otherwise cnt<=cnt+1.
  - The >= compare means a div decrease below the current cnt forces a tick next cycle.
  - div=0 gives a tick every enabled cycle.
- On tick (state registered, so the new sel is visible the cycle after the tick):
  - mask==0: sel held, wrap=0.
  - Up: sel becomes the next active index above sel, wrapping 7->0 circularly. wrap=1 if the search passed through the 7->0 boundary.
  - Down: sel becomes the next active index below sel, wrapping 0->7. wrap=1 if it crossed 0->7.
  - Ping-pong:
    - Search in direction dir without wrapping.
    - If none is found, toggle dir and search the opposite direction; wrap=1 on that reversal.
    - If still none is found (only sel active), sel is held, dir is toggled, and wrap=1.
  - Hold: sel held, wrap=0, cnt keeps counting.
  - Single active position equal to sel, in up/down modes: sel held, wrap=1 every tick.
  - Current sel inactive (mask changed): the search starts from sel as normal. The sel position itself is never selected unless it is the only active one.
- wrap is high for exactly one cycle, coincident with the new sel.
- Mode or mask changes take effect at the next tick. dir is kept when leaving ping-pong and reused on return.
- Search is combinational priority logic over the 8 positions (rotate plus priority encode); no multi-cycle search.
- Reset mid-scan returns all state to reset values immediately, independent of clk.

Test Plan:
- Reset with mask=8'hFF, mode=00, div=0, en=1 -> sel sequence 0,1,2,...,7,0 on consecutive cycles after release; wrap pulses coincident with sel=0 only; valid=1 throughout.
- div=3, mode=00, mask=8'hFF -> sel advances every 4 cycles. Change div to 1 mid-count with cnt=2 -> tick on the next cycle, then a step every 2 cycles.
- mask=8'b1010_0101, mode=01, starting at sel=0 -> sel 7,5,2,0,7; wrap at the 0->7 step; never visits 1,3,4,6.
- mask=8'b0001_1010, mode=10, div=0, starting at sel=1 -> sel 3,4,3,1,3,4; wrap pulses when sel=3 is produced after 4 and after 1.
- mask=8'h00 -> sel frozen, valid=0, no wrap. Then mask=8'h10 in mode 00 -> next tick sel=4, then sel=4 held with wrap each tick.
- en=0 for 10 cycles -> sel and cnt frozen at 0. Assert rst_n=0 asynchronously mid-period with sel=5 -> sel=0, wrap=0 immediately, without waiting for a clk edge.
